// File: rtl/vid_frame_read_pkg.sv
// Shared definitions for the frame-buffer reader: register map, CSR bit
// positions, FSM encoding and the burst sizing helper.
package vid_frame_read_pkg;

    localparam logic [1:0] REG_CSR    = 2'd0;
    localparam logic [1:0] REG_BASE   = 2'd1;
    localparam logic [1:0] REG_LEN    = 2'd2;
    localparam logic [1:0] REG_REMAIN = 2'd3;

    // CSR write bits
    localparam int CSR_START = 0;
    localparam int CSR_STOP  = 1;
    localparam int CSR_CLEAR = 2;
    localparam int CSR_LOOP  = 3;

    // CSR read bits (CSR_LOOP reads back at the same position)
    localparam int CSR_BUSY    = 0;
    localparam int CSR_DONE    = 1;
    localparam int CSR_ABORTED = 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CHECK = 2'd1;
    localparam logic [1:0] ST_REQ   = 2'd2;
    localparam logic [1:0] ST_DATA  = 2'd3;

    function automatic logic [7:0] burst_words(input logic [31:0] remain,
                                               input logic [7:0]  burst);
        return (remain < {24'd0, burst}) ? remain[7:0] : burst;
    endfunction

endpackage

// File: rtl/vid_frame_read_fifo.sv
// Synchronous FIFO with flush and free-space count (tag bit + data word).
// Latency: a pushed word is visible at the head one cycle later.
// Backpressure: caller must not push when full; pop on empty is ignored.
module vid_frame_read_fifo #(
    parameter int DW    = 33,
    parameter int DEPTH = 256,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk_1x,
    input  logic          rst_sys,
    input  logic          push,
    input  logic [DW-1:0] push_dat,
    input  logic          pop,
    input  logic          flush,
    output logic [DW-1:0] pop_dat,
    output logic          empty,
    output logic [CW-1:0] free
);
    localparam int AB = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AB-1:0] wr_ptr;
    logic [AB-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push_ok;
    logic          pop_ok;

    assign push_ok = push && (count != CW'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign empty   = (count == '0);
    assign free    = CW'(DEPTH) - count;
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk_1x) begin
        if (push_ok && !flush)
            mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge clk_1x or posedge rst_sys) begin
        if (rst_sys) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + AB'(1);
            if (pop_ok)
                rd_ptr <= rd_ptr + AB'(1);
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/vid_frame_read.sv
// Frame-buffer reader: memif bursts into a FIFO, out as a 32-bit word stream.
// Latency: 1 cycle from mi_rstb to out_valid; frame looping via VID_FRAME_READ_LOOP_EN.
// Backpressure: out_ready stalls pops; a burst is only requested once it fits the FIFO.
module vid_frame_read
    import vid_frame_read_pkg::*;
#(
    parameter int AW         = 22,
    parameter int BURST      = 64,
    parameter int FIFO_DEPTH = 256
) (
    input  logic          clk_1x,
    input  logic          rst_sys,
    output logic [AW-1:0] mi_addr,
    output logic [6:0]    mi_len,
    output logic          mi_rw,
    output logic          mi_valid,
    input  logic          mi_ready,
    output logic [31:0]   mi_wdata,
    input  logic          mi_wack,
    input  logic          mi_wlast,
    input  logic [31:0]   mi_rdata,
    input  logic          mi_rstb,
    input  logic          mi_rlast,
    output logic [31:0]   out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    input  logic [1:0]    wb_addr,
    input  logic [31:0]   wb_wdata,
    output logic [31:0]   wb_rdata,
    input  logic          wb_we,
    input  logic          wb_cyc,
    output logic          wb_ack
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]    state;
    logic [AW-1:0] addr;
    logic [AW-1:0] remain;
    logic [AW-1:0] base;
    logic [AW-1:0] len;
    logic          done;
    logic          aborted;
    logic          stop_pend;
    logic          loop_en;
    logic          busy;

    logic [7:0]    burst_n;
    logic          fits;
    logic          wb_wr;
    logic          wb_rd;
    logic          csr_wr;
    logic          start_now;
    logic          stop_now;
    logic          clr_now;
    logic          stop_any;
    logic          beat_last;
    logic [31:0]   rd_val;

    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_flush;
    logic          fifo_empty;
    logic [CW-1:0] fifo_free;
    logic [32:0]   fifo_dout;

    logic          unused_ok;
    assign unused_ok = ^{mi_wack, mi_wlast, wb_wdata};

    assign wb_wr     = wb_cyc && wb_we && !wb_ack;
    assign wb_rd     = wb_cyc && !wb_we && !wb_ack;
    assign csr_wr    = wb_wr && (wb_addr == REG_CSR);
    assign stop_now  = csr_wr && wb_wdata[CSR_STOP];
    assign start_now = csr_wr && wb_wdata[CSR_START] && !wb_wdata[CSR_STOP];
    assign clr_now   = csr_wr && wb_wdata[CSR_CLEAR];
    assign stop_any  = stop_now || stop_pend;

    assign busy      = (state != ST_IDLE) || !fifo_empty;
    assign burst_n   = burst_words(32'(remain), 8'(BURST));
    assign fits      = 32'(fifo_free) >= 32'(burst_n);
    assign beat_last = (state == ST_DATA) && mi_rstb && mi_rlast;

    assign mi_rw     = 1'b1;
    assign mi_wdata  = 32'd0;
    assign mi_valid  = (state == ST_REQ);
    assign mi_addr   = addr;
    assign mi_len    = (state == ST_REQ) ? 7'(burst_n - 8'd1) : 7'd0;

    // Words of an aborted burst are dropped on arrival; the FIFO is flushed once it ends.
    assign fifo_push  = (state == ST_DATA) && mi_rstb && !stop_any;
    assign fifo_flush = (stop_now && ((state == ST_IDLE) || (state == ST_CHECK)))
                     || (beat_last && stop_any);
    assign fifo_pop   = out_valid && out_ready;

    assign out_valid = !fifo_empty;
    assign out_data  = fifo_dout[31:0];
    assign out_last  = fifo_dout[32];

    vid_frame_read_fifo #(
        .DW    (33),
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk_1x   (clk_1x),
        .rst_sys  (rst_sys),
        .push     (fifo_push),
        .push_dat ({mi_rlast && (remain == '0), mi_rdata}),
        .pop      (fifo_pop),
        .flush    (fifo_flush),
        .pop_dat  (fifo_dout),
        .empty    (fifo_empty),
        .free     (fifo_free)
    );

`ifdef VID_FRAME_READ_LOOP_EN
    always_ff @(posedge clk_1x or posedge rst_sys) begin
        if (rst_sys)
            loop_en <= 1'b0;
        else if (csr_wr)
            loop_en <= wb_wdata[CSR_LOOP];
    end
`else
    assign loop_en = 1'b0;
`endif

    always_comb begin
        rd_val = 32'd0;
        case (wb_addr)
            REG_CSR:    rd_val = {28'd0, loop_en, aborted, done, busy};
            REG_BASE:   rd_val = 32'(base);
            REG_LEN:    rd_val = 32'(len);
            REG_REMAIN: rd_val = 32'(remain);
            default:    rd_val = 32'd0;
        endcase
    end

    always_ff @(posedge clk_1x or posedge rst_sys) begin
        if (rst_sys) begin
            wb_ack   <= 1'b0;
            wb_rdata <= 32'd0;
            base     <= '0;
            len      <= '0;
        end else begin
            wb_ack   <= wb_cyc && !wb_ack;
            wb_rdata <= wb_rd ? rd_val : 32'd0;
            if (wb_wr && (wb_addr == REG_BASE))
                base <= wb_wdata[AW-1:0];
            if (wb_wr && (wb_addr == REG_LEN))
                len <= wb_wdata[AW-1:0];
        end
    end

    always_ff @(posedge clk_1x or posedge rst_sys) begin
        if (rst_sys) begin
            state     <= ST_IDLE;
            addr      <= '0;
            remain    <= '0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            stop_pend <= 1'b0;
        end else begin
            if (clr_now) begin
                done    <= 1'b0;
                aborted <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (stop_now) begin
                        aborted <= 1'b1;
                    end else if (start_now && !busy) begin
                        if (len == '0) begin
                            done <= 1'b1;
                        end else begin
                            addr   <= base;
                            remain <= len;
                            state  <= ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    if (stop_now) begin
                        aborted <= 1'b1;
                        state   <= ST_IDLE;
                    end else if (fits) begin
                        state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (stop_now)
                        stop_pend <= 1'b1;
                    if (mi_ready) begin
                        addr   <= addr + AW'(burst_n);
                        remain <= remain - AW'(burst_n);
                        state  <= ST_DATA;
                    end
                end
                default: begin
                    if (stop_now)
                        stop_pend <= 1'b1;
                    if (beat_last) begin
                        if (stop_any) begin
                            stop_pend <= 1'b0;
                            aborted   <= 1'b1;
                            state     <= ST_IDLE;
                        end else if (remain == '0) begin
                            done <= 1'b1;
                            if (loop_en && (len != '0)) begin
                                addr   <= base;
                                remain <= len;
                                state  <= ST_CHECK;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            state <= ST_CHECK;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vid_frame_read.sv
// Directed bench for vid_frame_read: behavioural memif responder, stream monitor
// and Wishbone driver; build with VID_FRAME_READ_LOOP_EN to add the loop scenario.
module tb_vid_frame_read;
    import vid_frame_read_pkg::*;

    localparam int AW = 22;

    logic          clk_1x = 1'b0;
    logic          rst_sys;
    logic [AW-1:0] mi_addr;
    logic [6:0]    mi_len;
    logic          mi_rw;
    logic          mi_valid;
    logic          mi_ready;
    logic [31:0]   mi_wdata;
    logic          mi_wack;
    logic          mi_wlast;
    logic [31:0]   mi_rdata;
    logic          mi_rstb;
    logic          mi_rlast;
    logic [31:0]   out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic [1:0]    wb_addr;
    logic [31:0]   wb_wdata;
    logic [31:0]   wb_rdata;
    logic          wb_we;
    logic          wb_cyc;
    logic          wb_ack;

    int n_checks = 0;
    int n_fail   = 0;

    // memif responder state (written only by the responder)
    logic [AW-1:0] req_addr[$];
    logic [6:0]    req_len[$];
    int            words_sent = 0;
    int            req_delay;

    // stream monitor state (written only by the monitor)
    logic          mon_rst;
    logic [AW-1:0] exp_base;
    int            exp_len;
    int            out_cnt, out_idx, data_err, last_err, last_cnt, vio;
    logic          pv_valid, pv_ready;
    logic [AW-1:0] pv_addr;
    logic [6:0]    pv_len;

    vid_frame_read #(.AW(AW), .BURST(64), .FIFO_DEPTH(256)) dut (
        .clk_1x    (clk_1x),
        .rst_sys   (rst_sys),
        .mi_addr   (mi_addr),
        .mi_len    (mi_len),
        .mi_rw     (mi_rw),
        .mi_valid  (mi_valid),
        .mi_ready  (mi_ready),
        .mi_wdata  (mi_wdata),
        .mi_wack   (mi_wack),
        .mi_wlast  (mi_wlast),
        .mi_rdata  (mi_rdata),
        .mi_rstb   (mi_rstb),
        .mi_rlast  (mi_rlast),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .wb_addr   (wb_addr),
        .wb_wdata  (wb_wdata),
        .wb_rdata  (wb_rdata),
        .wb_we     (wb_we),
        .wb_cyc    (wb_cyc),
        .wb_ack    (wb_ack)
    );

    always #5 clk_1x = ~clk_1x;

    function automatic logic [31:0] pat(input logic [AW-1:0] a);
        return 32'h5A00_0000 ^ {10'd0, a};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // memif read responder: accept after req_delay cycles, then stream the burst
    initial begin
        logic [AW-1:0] ra;
        logic [6:0]    rl;
        mi_ready = 1'b0; mi_rstb = 1'b0; mi_rlast = 1'b0; mi_rdata = 32'd0;
        mi_wack  = 1'b0; mi_wlast = 1'b0;
        forever begin
            @(posedge clk_1x); #1;
            if (mi_valid && !rst_sys) begin
                repeat (req_delay) @(posedge clk_1x);
                #1;
                ra = mi_addr;
                rl = mi_len;
                req_addr.push_back(ra);
                req_len.push_back(rl);
                mi_ready = 1'b1;
                @(posedge clk_1x); #1;
                mi_ready = 1'b0;
                repeat (2) @(posedge clk_1x);
                #1;
                for (int i = 0; i <= int'(rl); i++) begin
                    mi_rstb  = 1'b1;
                    mi_rdata = pat(ra + AW'(i));
                    mi_rlast = (i == int'(rl));
                    words_sent++;
                    @(posedge clk_1x); #1;
                end
                mi_rstb = 1'b0; mi_rlast = 1'b0;
            end
        end
    end

    // stream and request-stability monitor
    always @(negedge clk_1x) begin
        if (mon_rst) begin
            out_cnt = 0; out_idx = 0; data_err = 0; last_err = 0; last_cnt = 0; vio = 0;
        end else begin
            if (out_valid && out_ready) begin
                if (out_data !== pat(exp_base + AW'(out_idx))) data_err++;
                if (out_last !== (out_idx == exp_len - 1)) last_err++;
                out_cnt++;
                if (out_last) begin
                    last_cnt++;
                    out_idx = 0;
                end else begin
                    out_idx++;
                end
            end
            if (pv_valid && !pv_ready && (!mi_valid || mi_addr !== pv_addr || mi_len !== pv_len))
                vio++;
        end
        pv_valid = mi_valid; pv_ready = mi_ready; pv_addr = mi_addr; pv_len = mi_len;
    end

    task automatic wb_write(input logic [1:0] a, input logic [31:0] d);
        @(posedge clk_1x); #1;
        wb_cyc = 1'b1; wb_we = 1'b1; wb_addr = a; wb_wdata = d;
        @(posedge clk_1x); #1;
        wb_cyc = 1'b0; wb_we = 1'b0;
    endtask

    task automatic wb_read(input logic [1:0] a, output logic [31:0] d);
        @(posedge clk_1x); #1;
        wb_cyc = 1'b1; wb_we = 1'b0; wb_addr = a;
        @(posedge clk_1x); #1;
        d = wb_ack ? wb_rdata : 32'hDEAD_BEEF;
        wb_cyc = 1'b0;
    endtask

    task automatic wait_csr(input string tag, input logic [31:0] mask,
                            input logic [31:0] val, input int budget);
        logic [31:0] r;
        bit ok = 1'b0;
        for (int n = 0; n < budget && !ok; n++) begin
            wb_read(REG_CSR, r);
            if ((r & mask) == val) ok = 1'b1;
        end
        check(tag, 32'(ok), 32'd1);
    endtask

    task automatic wait_reqs(input string tag, input int n, input int budget);
        int k = 0;
        while (req_addr.size() < n && k < budget) begin
            @(posedge clk_1x); k++;
        end
        check(tag, 32'(req_addr.size() >= n), 32'd1);
    endtask

    task automatic new_test(input logic [AW-1:0] b, input int l);
        wb_write(REG_CSR, 32'h4);
        exp_base = b;
        exp_len  = l;
        @(posedge clk_1x); #1 mon_rst = 1'b1;
        @(posedge clk_1x); #1 mon_rst = 1'b0;
        wb_write(REG_BASE, 32'(b));
        wb_write(REG_LEN, 32'(l));
    endtask

    initial begin
        logic [31:0] r;
        int rb, ws, k;
        rst_sys = 1'b1; mon_rst = 1'b1; req_delay = 1;
        out_ready = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0; wb_addr = 2'd0; wb_wdata = 32'd0;
        exp_base = '0; exp_len = 0;
        repeat (3) @(posedge clk_1x);
        #1 rst_sys = 1'b0; mon_rst = 1'b0;

        @(negedge clk_1x);
        check("rst_mi_valid", 32'(mi_valid), 32'd0);
        check("rst_mi_addr_len", {3'd0, mi_len, mi_addr}, 32'd0);
        check("rst_out", {30'd0, out_valid, out_last}, 32'd0);
        check("rst_wb", {wb_rdata[30:0], wb_ack}, 32'd0);
        check("rst_mi_const", {mi_wdata[30:0], mi_rw}, 32'd1);
        wb_read(REG_CSR, r);    check("rst_csr", r, 32'd0);
        wb_read(REG_REMAIN, r); check("rst_remain", r, 32'd0);

        // three bursts, continuous drain, restart attempt while busy
        new_test(22'h100, 150);
        out_ready = 1'b1;
        rb = req_addr.size();
        wb_write(REG_CSR, 32'h1);
        wait_reqs("t1_first_req", rb + 1, 200);
        wb_write(REG_CSR, 32'h1);
        wait_csr("t1_done", 32'h3, 32'h2, 400);
        check("t1_reqs", 32'(req_addr.size() - rb), 32'd3);
        check("t1_addr0", 32'(req_addr[rb]), 32'h100);
        check("t1_addr1", 32'(req_addr[rb + 1]), 32'h140);
        check("t1_addr2", 32'(req_addr[rb + 2]), 32'h180);
        check("t1_lens", {req_len[rb], req_len[rb + 1], req_len[rb + 2]}, {7'd63, 7'd63, 7'd21});
        check("t1_words", 32'(out_cnt), 32'd150);
        check("t1_data_err", 32'(data_err), 32'd0);
        check("t1_last", {16'(last_cnt), 16'(last_err)}, {16'd1, 16'd0});
        wb_read(REG_REMAIN, r); check("t1_remain", r, 32'd0);

        // consumer stalled: FIFO fills to its 256-word depth and further requests wait
        new_test(22'h2000, 300);
        out_ready = 1'b0;
        rb = req_addr.size();
        wb_write(REG_CSR, 32'h1);
        repeat (600) @(posedge clk_1x);
        #1;
        check("t2_stall_reqs", 32'(req_addr.size() - rb), 32'd4);
        check("t2_stall_out", {31'd0, out_valid}, 32'd1);
        wb_read(REG_REMAIN, r); check("t2_stall_remain", r, 32'd44);
        wb_read(REG_CSR, r);    check("t2_stall_csr", r, 32'h1);
        out_ready = 1'b1;
        wait_csr("t2_done", 32'h3, 32'h2, 400);
        check("t2_reqs", 32'(req_addr.size() - rb), 32'd5);
        check("t2_len4", 32'(req_len[rb + 4]), 32'd43);
        check("t2_words", 32'(out_cnt), 32'd300);
        check("t2_err", {16'(data_err), 16'(last_err)}, 32'd0);

        // stop while the second request is waiting for mi_ready
        new_test(22'h1000, 300);
        out_ready = 1'b1;
        req_delay = 8;
        rb = req_addr.size();
        ws = words_sent;
        wb_write(REG_CSR, 32'h1);
        wait_reqs("t3_first_req", rb + 1, 300);
        k = 0;
        while (!(mi_valid && !mi_ready && req_addr.size() == rb + 1) && k < 400) begin
            @(negedge clk_1x); k++;
        end
        check("t3_in_req", 32'(mi_valid), 32'd1);
        wb_write(REG_CSR, 32'h2);
        wait_csr("t3_abort", 32'h7, 32'h4, 300);
        repeat (50) @(posedge clk_1x);
        #1;
        check("t3_reqs", 32'(req_addr.size() - rb), 32'd2);
        check("t3_drained", 32'(words_sent - ws), 32'd128);
        check("t3_words", 32'(out_cnt), 32'd64);
        check("t3_hold_vio", 32'(vio), 32'd0);
        check("t3_no_last", {16'(last_cnt), 16'(data_err)}, 32'd0);
        wb_read(REG_CSR, r); check("t3_csr", r, 32'h4);
        req_delay = 1;

        // address wraps at 2^AW
        new_test(22'h3FFFF0, 80);
        rb = req_addr.size();
        wb_write(REG_CSR, 32'h1);
        wait_csr("t4_done", 32'h3, 32'h2, 400);
        check("t4_reqs", 32'(req_addr.size() - rb), 32'd2);
        check("t4_addr0", 32'(req_addr[rb]), 32'h3FFFF0);
        check("t4_addr1", 32'(req_addr[rb + 1]), 32'h000030);
        check("t4_len1", 32'(req_len[rb + 1]), 32'd15);
        check("t4_words", 32'(out_cnt), 32'd80);
        check("t4_err", {16'(data_err), 16'(last_err)}, 32'd0);

        // empty frame
        new_test(22'h500, 0);
        rb = req_addr.size();
        wb_write(REG_CSR, 32'h1);
        wb_read(REG_CSR, r); check("t5_csr", r, 32'h2);
        repeat (10) @(posedge clk_1x);
        #1;
        check("t5_no_req", 32'(req_addr.size() - rb), 32'd0);
        check("t5_no_out", 32'(out_cnt), 32'd0);

`ifdef VID_FRAME_READ_LOOP_EN
        new_test(22'h200, 8);
        rb = req_addr.size();
        wb_write(REG_CSR, 32'h9);
        k = 0;
        while (last_cnt < 3 && k < 2000) begin
            @(posedge clk_1x); k++;
        end
        check("t6_frames", 32'(last_cnt >= 3), 32'd1);
        wb_write(REG_CSR, 32'h2);
        wait_csr("t6_stop", 32'h5, 32'h4, 300);
        ws = req_addr.size();
        repeat (100) @(posedge clk_1x);
        #1;
        check("t6_no_more_req", 32'(req_addr.size() - ws), 32'd0);
        check("t6_err", {16'(data_err), 16'(last_err)}, 32'd0);
        wb_read(REG_CSR, r); check("t6_csr", r & 32'h7, 32'h6);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
